// File: rtl/blake2_pkg.sv
// Shared constants and state encoding for the BLAKE2s message sequencer.
package blake2_pkg;
    localparam int BB     = 64;
    localparam int NN_MAX = 32;
    localparam int LLW    = 64;
    localparam int IDXW   = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        HASH  = 2'd3
    } state_t;
endpackage

// File: rtl/blake2_blk_buf.sv
// 64x8 block buffer: one synchronous write port, one asynchronous read port.
module blake2_blk_buf
    import blake2_pkg::*;
(
    input  logic            clk,
    input  logic            we,
    input  logic [IDXW-1:0] waddr,
    input  logic [7:0]      wdata,
    input  logic [IDXW-1:0] raddr,
    output logic [7:0]      rdata
);
    logic [7:0] mem [BB];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/blake2s_msg_sched.sv
// Buffers a host byte stream into 64-byte blocks, feeds them to a BLAKE2s core
// with first/last/ll framing and zero padding, then forwards the digest bytes.
module blake2s_msg_sched
    import blake2_pkg::*;
(
    input  logic            clk,
    input  logic            nreset,
    input  logic            start_i,
    input  logic [5:0]      nn_i,
    input  logic            s_v_i,
    input  logic            s_last_i,
    input  logic [7:0]      s_data_i,
    output logic            s_ready_o,
    input  logic            empty_i,
    output logic [5:0]      core_kk_o,
    output logic [5:0]      core_nn_o,
    output logic [LLW-1:0]  core_ll_o,
    output logic            core_first_o,
    output logic            core_last_o,
    output logic            core_v_o,
    output logic [IDXW-1:0] core_idx_o,
    output logic [7:0]      core_data_o,
    input  logic            core_ready_i,
    input  logic            core_h_v_i,
    input  logic [7:0]      core_h_i,
    output logic            h_v_o,
    output logic            h_last_o,
    output logic [7:0]      h_o,
    output logic            busy_o,
    output logic            err_o,
    output logic [1:0]      dbg_state_o
);
    localparam logic [5:0] NN_LIM = 6'(NN_MAX);

    // Handshakes: a host byte moves on a cycle where s_v_i & s_ready_o, a block
    // byte moves where core_v_o & core_ready_i; neither side may retract data.
    state_t          state, state_nxt;
    logic [IDXW:0]   cnt;
    logic [IDXW-1:0] idx;
    logic [LLW-1:0]  ll;
    logic            first_q, last_q, err_q;
    logic [5:0]      nn_q, k;
    logic [7:0]      rdata;

    logic nn_ok, s_fire, c_fire, fill_done, drain_done, h_fire, h_done;

    assign nn_ok      = (nn_i != 6'd0) && (nn_i <= NN_LIM);
    assign s_fire     = (state == FILL) && s_v_i;
    assign c_fire     = (state == DRAIN) && core_ready_i;
    assign fill_done  = s_fire && ((cnt[IDXW-1:0] == 6'd63) || s_last_i);
    assign drain_done = c_fire && (idx == 6'd63);
    assign h_fire     = (state == HASH) && core_h_v_i;
    assign h_done     = h_fire && (k == nn_q - 6'd1);

    blake2_blk_buf u_buf (
        .clk   (clk),
        .we    (s_fire),
        .waddr (cnt[IDXW-1:0]),
        .wdata (s_data_i),
        .raddr (idx),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_i && nn_ok) state_nxt = empty_i ? DRAIN : FILL;
            FILL:  if (fill_done)        state_nxt = DRAIN;
            DRAIN: if (drain_done)       state_nxt = last_q ? HASH : FILL;
            HASH:  if (h_done)           state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // ll counts accepted bytes only, so during DRAIN it already covers the block end.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt     <= '0;
            idx     <= '0;
            ll      <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            nn_q    <= '0;
            k       <= '0;
        end else begin
            err_q <= (state == IDLE) && start_i && !nn_ok;
            case (state)
                IDLE: if (start_i && nn_ok) begin
                    nn_q    <= nn_i;
                    ll      <= '0;
                    first_q <= 1'b1;
                    last_q  <= empty_i;
                    cnt     <= '0;
                    idx     <= '0;
                    k       <= '0;
                end
                FILL: if (s_fire) begin
                    cnt <= cnt + 7'd1;
                    ll  <= ll + LLW'(1);
                    if (s_last_i) last_q <= 1'b1;
                end
                DRAIN: if (c_fire) begin
                    idx <= idx + 6'd1;
                    if (drain_done) begin
                        first_q <= 1'b0;
                        cnt     <= '0;
                    end
                end
                HASH: if (h_fire) k <= k + 6'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        s_ready_o   = (state == FILL);
        core_v_o    = c_fire;
        core_data_o = ((state == DRAIN) && ({1'b0, idx} < cnt)) ? rdata : 8'h00;
        h_v_o       = h_fire;
        h_last_o    = h_done;
        h_o         = h_fire ? core_h_i : 8'h00;
        busy_o      = (state != IDLE);
        dbg_state_o = state;
    end

    assign core_kk_o    = 6'd0;
    assign core_nn_o    = nn_q;
    assign core_ll_o    = ll;
    assign core_first_o = first_q;
    assign core_last_o  = last_q;
    assign core_idx_o   = idx;
    assign err_o        = err_q;
endmodule

// File: tb/tb_blake2s_msg_sched.sv
// Directed bench for blake2s_msg_sched: drives host bytes, models the core handshake, checks framing.
module tb_blake2s_msg_sched;
  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start_i = 1'b0;
  logic [5:0]  nn_i = '0;
  logic        s_v_i = 1'b0;
  logic        s_last_i = 1'b0;
  logic [7:0]  s_data_i = '0;
  logic        s_ready_o;
  logic        empty_i = 1'b0;
  logic [5:0]  core_kk_o, core_nn_o;
  logic [63:0] core_ll_o;
  logic        core_first_o, core_last_o, core_v_o;
  logic [5:0]  core_idx_o;
  logic [7:0]  core_data_o;
  logic        core_ready_i = 1'b0;
  logic        core_h_v_i = 1'b0;
  logic [7:0]  core_h_i = '0;
  logic        h_v_o, h_last_o;
  logic [7:0]  h_o;
  logic        busy_o, err_o;
  logic [1:0]  dbg_state_o;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_FILL = 2'd1, ST_DRAIN = 2'd2, ST_HASH = 2'd3;

  int tests = 0;
  int fails = 0;

  logic [7:0]  msg [65];
  logic [7:0]  dig [32];
  logic [7:0]  blk_d [64];
  logic        blk_first, blk_last;
  logic [63:0] blk_ll;
  int          blk_got;
  bit          blk_order_ok, blk_stable_ok, blk_hold_ok;
  logic        hv_seen [32];
  logic        hl_seen [32];
  logic [7:0]  ho_seen [32];
  logic        busy_after;

  blake2s_msg_sched dut (
    .clk(clk), .nreset(nreset), .start_i(start_i), .nn_i(nn_i),
    .s_v_i(s_v_i), .s_last_i(s_last_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .empty_i(empty_i), .core_kk_o(core_kk_o), .core_nn_o(core_nn_o), .core_ll_o(core_ll_o),
    .core_first_o(core_first_o), .core_last_o(core_last_o), .core_v_o(core_v_o),
    .core_idx_o(core_idx_o), .core_data_o(core_data_o), .core_ready_i(core_ready_i),
    .core_h_v_i(core_h_v_i), .core_h_i(core_h_i), .h_v_o(h_v_o), .h_last_o(h_last_o),
    .h_o(h_o), .busy_o(busy_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [5:0] nn, input logic e);
    @(negedge clk);
    start_i = 1'b1; nn_i = nn; empty_i = e;
    @(posedge clk); #1;
    start_i = 1'b0; empty_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int cyc = 0;
    @(negedge clk);
    s_v_i = 1'b1; s_data_i = b; s_last_i = l;
    #1;
    while (!s_ready_o && cyc < 500) begin
      @(negedge clk); #1; cyc++;
    end
    if (!s_ready_o) begin
      tests++; fails++;
      $display("FAIL send_timeout: s_ready_o=%0b required 1", s_ready_o);
    end
    @(posedge clk); #1;
    s_v_i = 1'b0; s_last_i = 1'b0;
  endtask

  task automatic send_msg(input int first_i, input int n, input logic with_last);
    for (int i = 0; i < n; i++) send_byte(msg[first_i + i], with_last && (i == n - 1));
  endtask

  // Acts as the core: accepts 64 block bytes and records framing seen on the first beat.
  task automatic drain_block(input bit rnd);
    int cyc = 0;
    logic [5:0] exp_idx = 6'd0;
    blk_got = 0; blk_order_ok = 1; blk_stable_ok = 1; blk_hold_ok = 1;
    for (int i = 0; i < 64; i++) blk_d[i] = 8'hxx;
    while (blk_got < 64 && cyc < 3000) begin
      @(negedge clk);
      core_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      cyc++;
      if (dbg_state_o == ST_DRAIN && !core_ready_i)
        if (core_v_o !== 1'b0 || core_idx_o !== exp_idx) blk_hold_ok = 0;
      if (core_v_o === 1'b1) begin
        if (blk_got == 0) begin
          blk_first = core_first_o; blk_last = core_last_o; blk_ll = core_ll_o;
        end else if (core_first_o !== blk_first || core_last_o !== blk_last || core_ll_o !== blk_ll) begin
          blk_stable_ok = 0;
        end
        if (core_idx_o !== exp_idx) blk_order_ok = 0;
        blk_d[core_idx_o] = core_data_o;
        blk_got++;
        exp_idx = exp_idx + 6'd1;
      end
    end
    @(negedge clk);
    core_ready_i = 1'b0;
    #1;
  endtask

  task automatic feed_digest(input int nn);
    for (int i = 0; i < nn; i++) begin
      @(negedge clk);
      core_h_v_i = 1'b1; core_h_i = dig[i];
      #1;
      hv_seen[i] = h_v_o; hl_seen[i] = h_last_o; ho_seen[i] = h_o;
    end
    @(negedge clk);
    core_h_v_i = 1'b0; core_h_i = 8'h00;
    #1;
    busy_after = busy_o;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset;
    core_ready_i = 1'b1;
    #1;
    tests++;
    if ({busy_o, s_ready_o, core_v_o, core_first_o, core_last_o, h_v_o, h_last_o, err_o} !== 8'h00) begin
      fails++;
      $display("FAIL reset_flags: got %b required 00000000",
               {busy_o, s_ready_o, core_v_o, core_first_o, core_last_o, h_v_o, h_last_o, err_o});
    end
    tests++;
    if ({core_ll_o, core_nn_o, core_kk_o, core_idx_o, core_data_o, h_o} !== '0) begin
      fails++;
      $display("FAIL reset_buses: ll=%0h nn=%0d kk=%0d idx=%0d data=%0h h=%0h required all 0",
               core_ll_o, core_nn_o, core_kk_o, core_idx_o, core_data_o, h_o);
    end
    tests++;
    if (dbg_state_o !== ST_IDLE) begin
      fails++; $display("FAIL reset_state: got %0d required %0d", dbg_state_o, ST_IDLE);
    end
    core_ready_i = 1'b0;
  endtask

  task automatic test_bad_nn;
    logic [5:0] bad [2];
    bad[0] = 6'd0; bad[1] = 6'd33;
    for (int t = 0; t < 2; t++) begin
      do_start(bad[t], 1'b0);
      tests++;
      if (err_o !== 1'b1) begin
        fails++; $display("FAIL err_pulse nn=%0d: got %b required 1", bad[t], err_o);
      end
      tests++;
      if (busy_o !== 1'b0) begin
        fails++; $display("FAIL err_busy nn=%0d: got %b required 0", bad[t], busy_o);
      end
      @(posedge clk); #1;
      tests++;
      if (err_o !== 1'b0 || busy_o !== 1'b0) begin
        fails++; $display("FAIL err_clear nn=%0d: err=%b busy=%b required 0 0", bad[t], err_o, busy_o);
      end
    end
  endtask

  task automatic test_empty;
    for (int i = 0; i < 32; i++) dig[i] = 8'(8'hA0 + i);
    do_start(6'd32, 1'b1);
    tests++;
    if (dbg_state_o !== ST_DRAIN || core_nn_o !== 6'd32) begin
      fails++; $display("FAIL empty_enter: state=%0d nn=%0d required 2 32", dbg_state_o, core_nn_o);
    end
    drain_block(1'b0);
    tests++;
    if (blk_got !== 64 || blk_first !== 1'b1 || blk_last !== 1'b1 || blk_ll !== 64'd0) begin
      fails++;
      $display("FAIL empty_frame: got=%0d first=%b last=%b ll=%0d required 64 1 1 0",
               blk_got, blk_first, blk_last, blk_ll);
    end
    for (int i = 0; i < 64; i++) begin
      tests++;
      if (blk_d[i] !== 8'h00) begin
        fails++; $display("FAIL empty_byte[%0d]: got %h required 00", i, blk_d[i]);
      end
    end
    tests++;
    if (dbg_state_o !== ST_HASH) begin
      fails++; $display("FAIL empty_to_hash: got %0d required %0d", dbg_state_o, ST_HASH);
    end
    feed_digest(32);
    for (int i = 0; i < 32; i++) begin
      tests++;
      if (hv_seen[i] !== 1'b1 || ho_seen[i] !== dig[i] || hl_seen[i] !== (i == 31)) begin
        fails++;
        $display("FAIL empty_digest[%0d]: v=%b h=%h last=%b required 1 %h %b",
                 i, hv_seen[i], ho_seen[i], hl_seen[i], dig[i], (i == 31));
      end
    end
    tests++;
    if (busy_after !== 1'b0) begin
      fails++; $display("FAIL empty_busy_end: got %b required 0", busy_after);
    end
  endtask

  task automatic test_abc;
    logic [255:0] abc_h = 256'h508C5E8C327C14E2E1A72BA34EEB452F37458B209ED63A294D999B4C86675982;
    for (int i = 0; i < 32; i++) dig[i] = abc_h[255 - 8*i -: 8];
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    do_start(6'd32, 1'b0);
    // a digest strobe during FILL must not leak out
    @(negedge clk);
    core_h_v_i = 1'b1; core_h_i = 8'h5A;
    #1;
    tests++;
    if (h_v_o !== 1'b0 || h_o !== 8'h00) begin
      fails++; $display("FAIL abc_h_ignored: v=%b h=%h required 0 00", h_v_o, h_o);
    end
    core_h_v_i = 1'b0; core_h_i = 8'h00;
    send_msg(0, 3, 1'b1);
    drain_block(1'b0);
    tests++;
    if (blk_got !== 64 || blk_first !== 1'b1 || blk_last !== 1'b1 || blk_ll !== 64'd3) begin
      fails++;
      $display("FAIL abc_frame: got=%0d first=%b last=%b ll=%0d required 64 1 1 3",
               blk_got, blk_first, blk_last, blk_ll);
    end
    for (int i = 0; i < 64; i++) begin
      tests++;
      if (blk_d[i] !== ((i < 3) ? msg[i] : 8'h00)) begin
        fails++; $display("FAIL abc_byte[%0d]: got %h required %h", i, blk_d[i], (i < 3) ? msg[i] : 8'h00);
      end
    end
    feed_digest(32);
    for (int i = 0; i < 32; i++) begin
      tests++;
      if (hv_seen[i] !== 1'b1 || ho_seen[i] !== dig[i] || hl_seen[i] !== (i == 31)) begin
        fails++;
        $display("FAIL abc_digest[%0d]: v=%b h=%h last=%b required 1 %h %b",
                 i, hv_seen[i], ho_seen[i], hl_seen[i], dig[i], (i == 31));
      end
    end
    tests++;
    if (busy_after !== 1'b0) begin
      fails++; $display("FAIL abc_busy_end: got %b required 0", busy_after);
    end
  endtask

  task automatic test_full_block;
    for (int i = 0; i < 64; i++) msg[i] = 8'(i * 3 + 1);
    for (int i = 0; i < 16; i++) dig[i] = 8'(8'hF0 - i);
    do_start(6'd16, 1'b0);
    send_msg(0, 64, 1'b1);
    drain_block(1'b0);
    tests++;
    if (blk_got !== 64 || blk_first !== 1'b1 || blk_last !== 1'b1 || blk_ll !== 64'd64) begin
      fails++;
      $display("FAIL full_frame: got=%0d first=%b last=%b ll=%0d required 64 1 1 64",
               blk_got, blk_first, blk_last, blk_ll);
    end
    for (int i = 0; i < 64; i++) begin
      tests++;
      if (blk_d[i] !== msg[i]) begin
        fails++; $display("FAIL full_byte[%0d]: got %h required %h", i, blk_d[i], msg[i]);
      end
    end
    tests++;
    if (dbg_state_o !== ST_HASH || s_ready_o !== 1'b0) begin
      fails++; $display("FAIL full_no_extra_block: state=%0d ready=%b required 3 0", dbg_state_o, s_ready_o);
    end
    feed_digest(16);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (hv_seen[i] !== 1'b1 || ho_seen[i] !== dig[i] || hl_seen[i] !== (i == 15)) begin
        fails++;
        $display("FAIL full_digest[%0d]: v=%b h=%h last=%b required 1 %h %b",
                 i, hv_seen[i], ho_seen[i], hl_seen[i], dig[i], (i == 15));
      end
    end
    tests++;
    if (busy_after !== 1'b0) begin
      fails++; $display("FAIL full_busy_end: got %b required 0", busy_after);
    end
  endtask

  task automatic test_two_blocks;
    for (int i = 0; i < 65; i++) msg[i] = 8'(8'h80 ^ i);
    dig[0] = 8'h3C;
    do_start(6'd1, 1'b0);
    send_msg(0, 64, 1'b0);
    drain_block(1'b0);
    tests++;
    if (blk_got !== 64 || blk_first !== 1'b1 || blk_last !== 1'b0 || blk_ll !== 64'd64) begin
      fails++;
      $display("FAIL two_blk0_frame: got=%0d first=%b last=%b ll=%0d required 64 1 0 64",
               blk_got, blk_first, blk_last, blk_ll);
    end
    for (int i = 0; i < 64; i++) begin
      tests++;
      if (blk_d[i] !== msg[i]) begin
        fails++; $display("FAIL two_blk0_byte[%0d]: got %h required %h", i, blk_d[i], msg[i]);
      end
    end
    tests++;
    if (dbg_state_o !== ST_FILL || s_ready_o !== 1'b1) begin
      fails++; $display("FAIL two_back_to_fill: state=%0d ready=%b required 1 1", dbg_state_o, s_ready_o);
    end
    send_msg(64, 1, 1'b1);
    drain_block(1'b0);
    tests++;
    if (blk_got !== 64 || blk_first !== 1'b0 || blk_last !== 1'b1 || blk_ll !== 64'd65) begin
      fails++;
      $display("FAIL two_blk1_frame: got=%0d first=%b last=%b ll=%0d required 64 0 1 65",
               blk_got, blk_first, blk_last, blk_ll);
    end
    for (int i = 0; i < 64; i++) begin
      tests++;
      if (blk_d[i] !== ((i == 0) ? msg[64] : 8'h00)) begin
        fails++; $display("FAIL two_blk1_byte[%0d]: got %h required %h", i, blk_d[i], (i == 0) ? msg[64] : 8'h00);
      end
    end
    feed_digest(1);
    tests++;
    if (hv_seen[0] !== 1'b1 || ho_seen[0] !== 8'h3C || hl_seen[0] !== 1'b1 || busy_after !== 1'b0) begin
      fails++;
      $display("FAIL two_digest: v=%b h=%h last=%b busy=%b required 1 3c 1 0",
               hv_seen[0], ho_seen[0], hl_seen[0], busy_after);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 10; i++) msg[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 4; i++) dig[i] = 8'(8'h11 * (i + 1));
    do_start(6'd4, 1'b0);
    send_msg(0, 10, 1'b1);
    drain_block(1'b1);
    tests++;
    if (blk_got !== 64 || blk_order_ok !== 1'b1 || blk_hold_ok !== 1'b1 || blk_stable_ok !== 1'b1) begin
      fails++;
      $display("FAIL bp_handshake: got=%0d order=%b hold=%b stable=%b required 64 1 1 1",
               blk_got, blk_order_ok, blk_hold_ok, blk_stable_ok);
    end
    tests++;
    if (blk_first !== 1'b1 || blk_last !== 1'b1 || blk_ll !== 64'd10) begin
      fails++; $display("FAIL bp_frame: first=%b last=%b ll=%0d required 1 1 10", blk_first, blk_last, blk_ll);
    end
    for (int i = 0; i < 64; i++) begin
      tests++;
      if (blk_d[i] !== ((i < 10) ? msg[i] : 8'h00)) begin
        fails++; $display("FAIL bp_byte[%0d]: got %h required %h", i, blk_d[i], (i < 10) ? msg[i] : 8'h00);
      end
    end
    feed_digest(4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (hv_seen[i] !== 1'b1 || ho_seen[i] !== dig[i] || hl_seen[i] !== (i == 3)) begin
        fails++;
        $display("FAIL bp_digest[%0d]: v=%b h=%h last=%b required 1 %h %b",
                 i, hv_seen[i], ho_seen[i], hl_seen[i], dig[i], (i == 3));
      end
    end
  endtask

  task automatic test_reset_mid_drain;
    for (int i = 0; i < 5; i++) msg[i] = 8'(8'h40 + i);
    do_start(6'd8, 1'b0);
    send_msg(0, 5, 1'b1);
    @(negedge clk);
    core_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (dbg_state_o !== ST_DRAIN || core_idx_o !== 6'd3) begin
      fails++; $display("FAIL mid_pre_reset: state=%0d idx=%0d required 2 3", dbg_state_o, core_idx_o);
    end
    #1 nreset = 1'b0;
    #1;
    tests++;
    if ({busy_o, s_ready_o, core_v_o, core_first_o, core_last_o, h_v_o, err_o} !== 7'h00 ||
        {core_ll_o, core_nn_o, core_idx_o, core_data_o} !== '0) begin
      fails++;
      $display("FAIL mid_async_reset: flags=%b ll=%0d nn=%0d idx=%0d data=%h required all 0",
               {busy_o, s_ready_o, core_v_o, core_first_o, core_last_o, h_v_o, err_o},
               core_ll_o, core_nn_o, core_idx_o, core_data_o);
    end
    core_ready_i = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    msg[0] = 8'hC1; msg[1] = 8'hC2;
    for (int i = 0; i < 8; i++) dig[i] = 8'(8'h70 + i);
    do_start(6'd8, 1'b0);
    send_msg(0, 2, 1'b1);
    drain_block(1'b0);
    tests++;
    if (blk_got !== 64 || blk_first !== 1'b1 || blk_last !== 1'b1 || blk_ll !== 64'd2) begin
      fails++;
      $display("FAIL mid_fresh_frame: got=%0d first=%b last=%b ll=%0d required 64 1 1 2",
               blk_got, blk_first, blk_last, blk_ll);
    end
    for (int i = 0; i < 64; i++) begin
      tests++;
      if (blk_d[i] !== ((i < 2) ? msg[i] : 8'h00)) begin
        fails++; $display("FAIL mid_fresh_byte[%0d]: got %h required %h", i, blk_d[i], (i < 2) ? msg[i] : 8'h00);
      end
    end
    feed_digest(8);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (hv_seen[i] !== 1'b1 || ho_seen[i] !== dig[i] || hl_seen[i] !== (i == 7)) begin
        fails++;
        $display("FAIL mid_fresh_digest[%0d]: v=%b h=%h last=%b required 1 %h %b",
                 i, hv_seen[i], ho_seen[i], hl_seen[i], dig[i], (i == 7));
      end
    end
    tests++;
    if (busy_after !== 1'b0) begin
      fails++; $display("FAIL mid_fresh_busy_end: got %b required 0", busy_after);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    test_bad_nn;
    test_empty;
    test_abc;
    test_full_block;
    test_two_blocks;
    test_backpressure;
    test_reset_mid_drain;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
